// File: rtl/core_pkg.sv
// Shared definitions for the write-back / trap stage:
// write-back select codes, FSM encoding, cause numbering.
package core_pkg;

  localparam logic [1:0] WRITE_SEL_ALU  = 2'd0;
  localparam logic [1:0] WRITE_SEL_CSR  = 2'd1;
  localparam logic [1:0] WRITE_SEL_LOAD = 2'd2;
  localparam logic [1:0] WRITE_SEL_NPC  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SLEEP     = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } wb_state_e;

  localparam int unsigned EXC_INSN_MISALIGN = 0;
  localparam int unsigned EXC_INSN_FAULT    = 1;
  localparam int unsigned EXC_ILLEGAL       = 2;
  localparam int unsigned EXC_BREAKPOINT    = 3;
  localparam int unsigned EXC_LOAD_MISALIGN = 4;
  localparam int unsigned EXC_LOAD_FAULT    = 5;
  localparam int unsigned EXC_STORE_MISALIGN = 6;
  localparam int unsigned EXC_STORE_FAULT   = 7;
  localparam int unsigned EXC_ECALL_M       = 11;

  // Source i lands on the machine-level cause slots 3, 7, 11, 15.
  function automatic int unsigned IRQ_CAUSE(input int idx);
    return 32'(4 * idx + 3);
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority interrupt encoder: the highest pending
// index wins and is mapped to its trap cause.
module irq_priority_enc
  import core_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int CAUSE_W = 5
) (
  input  logic [NUM_IRQ-1:0] pending_i,
  output logic               any_o,
  output logic [CAUSE_W-1:0] cause_o
);

  assign any_o = |pending_i;

  always_comb begin
    cause_o = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending_i[i]) cause_o = CAUSE_W'(IRQ_CAUSE(i));
    end
  end

endmodule

// File: rtl/writeback_trap_unit.sv
// Final pipeline stage: register write-back commit, trap
// prioritisation with CSR handshake, WFI sleep and instret.
module writeback_trap_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter int              NUM_IRQ  = 3,
  parameter int              CAUSE_W  = 5,
  parameter int              CNT_W    = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    next_pc,
  input  logic [XLEN-1:0]    alu_data,
  input  logic [XLEN-1:0]    csr_data,
  input  logic [XLEN-1:0]    load_data,
  input  logic [1:0]         write_select,
  input  logic [REG_AW-1:0]  rd_addr_in,
  input  logic               mret_in,
  input  logic               wfi_in,
  input  logic               exception,
  input  logic [CAUSE_W-1:0] ecause_in,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic               irq_enable,
  input  logic               trap_ready,
  output logic [REG_AW-1:0]  rd_addr_out,
  output logic [XLEN-1:0]    rd_data,
  output logic               mret_out,
  output logic               stall,
  output logic               trap_valid,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               trap_interrupt,
  output logic [XLEN-1:0]    trap_epc,
  output logic [CNT_W-1:0]   instret
);

  wb_state_e          state_q;
  logic               trap_valid_q;
  logic [CAUSE_W-1:0] trap_cause_q;
  logic               trap_int_q;
  logic [XLEN-1:0]    trap_epc_q;
  logic [CNT_W-1:0]   instret_q;
  logic [XLEN-1:0]    resume_pc_q;

  logic               irq_any;
  logic [CAUSE_W-1:0] irq_cause;
  logic               irq_take;
  logic               in_run;
  logic               trap_now;
  logic               commit;
  logic [XLEN-1:0]    rd_data_d;

  irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_irq_enc (
    .pending_i (irq_pending),
    .any_o     (irq_any),
    .cause_o   (irq_cause)
  );

  assign irq_take = irq_enable && irq_any;
  assign in_run   = (state_q == ST_RUN);
  assign trap_now = in_run && (irq_take || (valid && exception));
  assign commit   = in_run && valid && !trap_now;

  always_comb begin
    rd_data_d = alu_data;
    unique case (write_select)
      WRITE_SEL_ALU:  rd_data_d = alu_data;
      WRITE_SEL_CSR:  rd_data_d = csr_data;
      WRITE_SEL_LOAD: rd_data_d = load_data;
      WRITE_SEL_NPC:  rd_data_d = next_pc;
      default:        rd_data_d = alu_data;
    endcase
  end

  assign rd_data     = rd_data_d;
  assign rd_addr_out = commit ? rd_addr_in : '0;
  assign mret_out    = commit && mret_in;
  assign stall       = !in_run;

  assign trap_valid     = trap_valid_q;
  assign trap_cause     = trap_cause_q;
  assign trap_interrupt = trap_int_q;
  assign trap_epc       = trap_epc_q;
  assign instret        = instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      trap_valid_q <= 1'b0;
      trap_cause_q <= '0;
      trap_int_q   <= 1'b0;
      trap_epc_q   <= '0;
      instret_q    <= '0;
      resume_pc_q  <= RESET_PC;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_now) begin
            trap_valid_q <= 1'b1;
            trap_cause_q <= irq_take ? irq_cause : ecause_in;
            trap_int_q   <= irq_take;
            trap_epc_q   <= valid ? pc : resume_pc_q;
            state_q      <= ST_TRAP_WAIT;
          end else if (commit) begin
            instret_q   <= instret_q + CNT_W'(1);
            resume_pc_q <= next_pc;
            if (wfi_in) state_q <= ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          // Masked-off interrupts still wake the core.
          if (irq_any) begin
            if (irq_enable) begin
              trap_valid_q <= 1'b1;
              trap_cause_q <= irq_cause;
              trap_int_q   <= 1'b1;
              trap_epc_q   <= resume_pc_q;
              state_q      <= ST_TRAP_WAIT;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_TRAP_WAIT: begin
          if (trap_ready) begin
            trap_valid_q <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_trap_unit.sv
// Directed plus randomized bench for writeback_trap_unit
// against a cycle-level behavioural model.
module tb_writeback_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] pc, next_pc, alu_data, csr_data, load_data;
  logic [1:0]  write_select;
  logic [4:0]  rd_addr_in;
  logic        mret_in, wfi_in, exception;
  logic [4:0]  ecause_in;
  logic [2:0]  irq_pending;
  logic        irq_enable, trap_ready;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data;
  logic        mret_out, stall, trap_valid;
  logic [4:0]  trap_cause;
  logic        trap_interrupt;
  logic [31:0] trap_epc;
  logic [63:0] instret;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: 0 running, 1 sleeping, 2 waiting for CSR
  int          m_mode;
  logic        m_tv, m_int;
  logic [4:0]  m_cause;
  logic [31:0] m_epc, m_resume;
  logic [63:0] m_instret;

  always #5 clk = ~clk;

  writeback_trap_unit dut (
    .clk(clk), .reset(reset), .valid(valid), .pc(pc),
    .next_pc(next_pc), .alu_data(alu_data),
    .csr_data(csr_data), .load_data(load_data),
    .write_select(write_select), .rd_addr_in(rd_addr_in),
    .mret_in(mret_in), .wfi_in(wfi_in),
    .exception(exception), .ecause_in(ecause_in),
    .irq_pending(irq_pending), .irq_enable(irq_enable),
    .trap_ready(trap_ready), .rd_addr_out(rd_addr_out),
    .rd_data(rd_data), .mret_out(mret_out), .stall(stall),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_interrupt(trap_interrupt), .trap_epc(trap_epc),
    .instret(instret)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tv = 0; m_int = 0; m_cause = 0;
    m_epc = 0; m_resume = 32'h0; m_instret = 0;
  endtask

  task automatic idle();
    valid = 0; pc = 0; next_pc = 0; alu_data = 0; csr_data = 0;
    load_data = 0; write_select = 0; rd_addr_in = 0;
    mret_in = 0; wfi_in = 0; exception = 0; ecause_in = 0;
    irq_pending = 0; irq_enable = 0; trap_ready = 0;
  endtask

  // Check outputs mid-cycle, then advance model and DUT one edge.
  task automatic cycle();
    int h;
    logic [31:0] wd;
    logic take, trap, commit;
    @(negedge clk);
    h = -1;
    for (int i = 0; i < 3; i++) if (irq_pending[i]) h = i;
    case (write_select)
      2'd0: wd = alu_data;
      2'd1: wd = csr_data;
      2'd2: wd = load_data;
      default: wd = next_pc;
    endcase
    take   = irq_enable && (h >= 0);
    trap   = (m_mode == 0) && (take || (valid && exception));
    commit = (m_mode == 0) && valid && !trap;
    check("rd_addr_out", 64'(rd_addr_out), commit ? 64'(rd_addr_in) : 0);
    check("rd_data", 64'(rd_data), 64'(wd));
    check("mret_out", 64'(mret_out), 64'(commit && mret_in));
    check("stall", 64'(stall), 64'(m_mode != 0));
    check("trap_valid", 64'(trap_valid), 64'(m_tv));
    check("trap_cause", 64'(trap_cause), 64'(m_cause));
    check("trap_interrupt", 64'(trap_interrupt), 64'(m_int));
    check("trap_epc", 64'(trap_epc), 64'(m_epc));
    check("instret", instret, m_instret);
    if (m_mode == 0) begin
      if (trap) begin
        m_tv = 1; m_int = take;
        m_cause = take ? 5'(4 * h + 3) : ecause_in;
        m_epc = valid ? pc : m_resume;
        m_mode = 2;
      end else if (commit) begin
        m_instret = m_instret + 1;
        m_resume = next_pc;
        if (wfi_in) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (h >= 0) begin
        if (irq_enable) begin
          m_tv = 1; m_int = 1; m_cause = 5'(4 * h + 3);
          m_epc = m_resume; m_mode = 2;
        end else m_mode = 0;
      end
    end else if (trap_ready) begin
      m_tv = 0; m_mode = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    #1;
    check("rst trap_valid", 64'(trap_valid), 0);
    check("rst stall", 64'(stall), 0);
    check("rst instret", instret, 0);
    model_reset();
    #1;
    reset = 0;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check("reset epc", 64'(trap_epc), 0);
    cycle();

    // plain commit of next_pc
    valid = 1; write_select = 2'd3; rd_addr_in = 5;
    pc = 32'h100; next_pc = 32'h104;
    @(negedge clk);
    check("commit rd", 64'(rd_addr_out), 5);
    check("commit data", 64'(rd_data), 64'h104);
    @(posedge clk); #1;
    m_instret = 1; m_resume = 32'h104;
    idle();
    cycle();
    check("instret 1", instret, 1);

    // synchronous exception held against CSR backpressure
    valid = 1; exception = 1; ecause_in = 2; pc = 32'h200;
    rd_addr_in = 9;
    cycle();
    idle();
    repeat (3) cycle();
    check("exc cause", 64'(trap_cause), 2);
    check("exc epc", 64'(trap_epc), 64'h200);
    check("exc stall", 64'(stall), 1);
    trap_ready = 1;
    cycle();
    trap_ready = 0;
    cycle();
    check("exc released", 64'(trap_valid), 0);

    // interrupt beats concurrent exception
    valid = 1; exception = 1; ecause_in = 4; pc = 32'h300;
    irq_pending = 3'b110; irq_enable = 1;
    cycle();
    idle();
    cycle();
    check("irq cause", 64'(trap_cause), 11);
    check("irq flag", 64'(trap_interrupt), 1);
    trap_ready = 1;
    cycle();
    idle();

    // WFI woken by masked interrupt
    valid = 1; wfi_in = 1; next_pc = 32'h80; pc = 32'h7c;
    cycle();
    idle();
    repeat (10) cycle();
    check("sleep stall", 64'(stall), 1);
    irq_pending = 3'b010;
    cycle();
    idle();
    cycle();
    check("wake no trap", 64'(trap_valid), 0);

    // WFI woken by enabled interrupt
    valid = 1; wfi_in = 1; next_pc = 32'h80; pc = 32'h7c;
    cycle();
    idle();
    repeat (4) cycle();
    irq_pending = 3'b010; irq_enable = 1;
    cycle();
    idle();
    cycle();
    check("wfi cause", 64'(trap_cause), 7);
    check("wfi epc", 64'(trap_epc), 64'h80);

    // reset while waiting on the CSR unit
    pulse_reset();
    cycle();
    irq_pending = 3'b001; irq_enable = 1;
    cycle();
    idle();
    cycle();
    check("post-rst epc", 64'(trap_epc), 0);
    check("post-rst cause", 64'(trap_cause), 3);
    trap_ready = 1;
    cycle();

    for (int n = 0; n < 3000; n++) begin
      valid = 1'($urandom_range(0, 3) != 0);
      pc = $urandom; next_pc = $urandom;
      alu_data = $urandom; csr_data = $urandom;
      load_data = $urandom;
      write_select = 2'($urandom_range(0, 3));
      rd_addr_in = 5'($urandom_range(0, 31));
      mret_in = 1'($urandom_range(0, 7) == 0);
      wfi_in = 1'($urandom_range(0, 9) == 0);
      exception = 1'($urandom_range(0, 7) == 0);
      ecause_in = 5'($urandom_range(0, 31));
      irq_pending = ($urandom_range(0, 11) == 0) ?
                    3'($urandom_range(1, 7)) : 3'b000;
      irq_enable = 1'($urandom_range(0, 1));
      trap_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) pulse_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_trap_unit.md
Name: writeback_trap_unit

Overview:
Parametrised final pipeline stage. It selects and commits the register write-back and prioritises N interrupt sources against synchronous exceptions. A registered trap request is held to the CSR unit under a valid/ready handshake, and a WFI sleep state machine wakes on pending interrupts. It also keeps the resume PC and the retired-instruction counter.

Parameters:
XLEN, 32, datapath and PC width
REG_AW, 5, register-file address width
NUM_IRQ, 3, interrupt sources; source i maps to cause 4*i+3; higher index wins; legal range 1..4
CAUSE_W, 5, trap cause width
CNT_W, 64, retired-instruction counter width
RESET_PC, 32'h0, reset value of the resume PC

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  WB slot holds an instruction
pc  in  XLEN  PC of the WB instruction
next_pc  in  XLEN  sequential successor PC
alu_data  in  XLEN  ALU result
csr_data  in  XLEN  CSR read data
load_data  in  XLEN  load data
write_select  in  2  0=ALU, 1=CSR, 2=LOAD, 3=NEXT_PC (constants in package)
rd_addr_in  in  REG_AW  destination register
mret_in  in  1  instruction is MRET
wfi_in  in  1  instruction is WFI
exception  in  1  synchronous exception flagged upstream
ecause_in  in  CAUSE_W  exception cause
irq_pending  in  NUM_IRQ  level interrupt pending bits (already masked by mie)
irq_enable  in  1  global interrupt enable (mstatus.MIE)
trap_ready  in  1  CSR unit accepts the trap
rd_addr_out  out  REG_AW  write address; 0 means no write
rd_data  out  XLEN  write data
mret_out  out  1  MRET commits this cycle
stall  out  1  freeze upstream pipeline
trap_valid  out  1  registered trap request
trap_cause  out  CAUSE_W  registered cause
trap_interrupt  out  1  registered interrupt flag
trap_epc  out  XLEN  registered exception PC
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous): state=RUN; trap_valid=0, trap_cause=0, trap_interrupt=0, trap_epc=0; instret=0; resume_pc=RESET_PC.
- Outputs derived from reset registers: rd_addr_out=0, mret_out=0, stall=0.
- irq_take = irq_enable && |irq_pending. Taken irq cause = 4*(highest set index)+3.
- trap_now, in RUN = irq_take || (valid && exception). Interrupts take priority over exceptions.
- Combinational in RUN: commit = valid && !trap_now.
  - rd_addr_out = commit ? rd_addr_in : 0.
  - rd_data is the write_select mux, driven for every select value with no latch.
  - mret_out = commit && mret_in.
- Registered on commit: instret+1 (wraps modulo 2^CNT_W); resume_pc<=next_pc.
- EPC: trap_epc <= valid ? pc : resume_pc. An interrupt with an empty slot resumes at the next unexecuted PC.
- FSM states:
  - RUN, on trap_now: latch trap_cause/trap_interrupt/trap_epc; trap_valid<=1; go to TRAP_WAIT. The WB instruction is not retired.
  - RUN, on commit && wfi_in: go to SLEEP. The WFI counts as retired.
  - SLEEP: stall=1; rd_addr_out=0; valid is ignored.
    - |irq_pending && irq_enable: latch trap with epc=resume_pc; go to TRAP_WAIT.
    - |irq_pending && !irq_enable: go to RUN.
    - Otherwise stay.
  - TRAP_WAIT: stall=1; trap_valid held with all trap fields stable; rd_addr_out=0. On trap_ready: trap_valid<=0; go to RUN (1-cycle gap before the next trap).
- stall = (state != RUN). In RUN, stall=0 even in the trap cycle; the trap flush is the CSR unit's responsibility.
- trap_ready while trap_valid=0 is ignored.
- Reset asserted mid-TRAP_WAIT or mid-SLEEP: immediate return to the reset values; a pending trap is dropped.

Decomposition:
- Shared package `core_pkg`:
  - WRITE_SEL_* constants.
  - FSM state encoding (RUN, SLEEP, TRAP_WAIT).
  - IRQ_CAUSE(i) function.
  - Exception cause constants.
- One sub-module, `irq_priority_enc`, parametrised by NUM_IRQ: outputs any_pending and the cause.

Test Plan:
- Commit, write_select=3, valid=1, rd_addr_in=5, next_pc=0x104, no trap -> rd_addr_out=5, rd_data=0x104; instret 0->1 next cycle.
- valid, exception=1, ecause_in=2, pc=0x200 -> rd_addr_out=0 in that cycle; next cycle trap_valid=1, cause=2, interrupt=0, epc=0x200. Hold trap_ready=0 for 3 cycles -> fields stable, stall=1. Then trap_ready=1 -> trap_valid=0 on the next edge.
- irq_pending=3'b110, irq_enable=1, plus a concurrent exception -> trap_cause=11, trap_interrupt=1; the exception is discarded.
- Commit WFI with next_pc=0x80 -> stall=1 for 10 cycles.
  - Then irq_pending=3'b010 with irq_enable=0 -> back to RUN, no trap.
  - Repeat with irq_enable=1 -> trap cause 7, epc=0x80.
- Reset pulsed while in TRAP_WAIT -> trap_valid=0 and stall=0 immediately, instret=0, and the next empty-slot interrupt has epc=RESET_PC.
